writeback_module: RTL and testbench
===================================

WRITEBACK_MODULE -- requirements
Module: writeback_module

Interface
REQ-001 The module SHALL take parameter: BEATS, 4, number of 32-bit memory beats per 128-bit vector load; legal values are 2 and 4.
REQ-002 The module SHALL have these ports, clock and reset first:
  - clk  input  1  single clock; all state updates on rising edge.
  - rst  input  1  reset; asynchronous, active-high.
  - valid_m  input  1  memory-stage instruction valid this cycle.
  - wreg_m  input  1  instruction writes a register.
  - rmem_m  input  1  instruction is a load.
  - VF_m  input  1  instruction targets the vector register file.
  - R_V_dest_m  input  4  destination register index.
  - ALURes_m  input  128  ALU or vector-unit result; scalar result in [31:0].
  - MemData  input  32  data-memory read word.
  - mem_rvalid  input  1  MemData holds a valid beat this cycle.
  - Wreg3  output  1  register-file write enable to decode stage.
  - VF3  output  1  selects the vector file (1) or the scalar file (0) for the write.
  - R_V_dest3  output  4  write address to decode stage.
  - ResRV2  output  128  write data to decode stage.
  - stall  output  1  holds the memory stage and earlier stages.

Function
REQ-003 An instruction SHALL be accepted only when valid_m=1 and stall=0; inputs SHALL be ignored while stall=1.
REQ-004 The FSM SHALL have the states IDLE, WAIT_S, COLLECT and COMMIT.
REQ-005 Non-load accept (rmem_m=0) SHALL stay in IDLE and register the write, as follows:
  - Wreg3 = wreg_m, VF3 = VF_m, R_V_dest3 = R_V_dest_m.
  - ResRV2 = ALURes_m.
  - All these values are visible the cycle after accept, giving a latency of 1.
REQ-006 A scalar load accept (rmem_m=1, VF_m=0) SHALL behave as follows:
  - If mem_rvalid=1 in the accept cycle, it commits as in REQ-005 with ResRV2 = {96'h0, MemData}.
  - Otherwise, it goes to WAIT_S with stall=1 and commits the cycle after the first mem_rvalid=1.
REQ-007 A vector load accept (rmem_m=1, VF_m=1) SHALL handle its beats as follows:
  - It enters COLLECT and clears the beat counter.
  - Each cycle with mem_rvalid=1, it stores MemData into lane [32k+31:32k], where k is the beat counter, and then increments k.
  - Beats arriving in the accept cycle are not captured.
REQ-008 Once BEATS beats have been stored, the FSM SHALL move to COMMIT, as follows:
  - In COMMIT it drives Wreg3 = 1, VF3 = 1, R_V_dest3 = the latched destination, and ResRV2 = the assembled vector, for exactly 1 cycle.
  - It then returns to IDLE.
REQ-009 stall SHALL be 1 in WAIT_S and COLLECT and in the vector-load accept cycle, and 0 in IDLE and COMMIT.
  - A new instruction may therefore be accepted in the COMMIT cycle.
REQ-010 Wreg3 SHALL be a single-cycle pulse per committed instruction and 0 in all other cycles.
REQ-011 A scalar write to R_V_dest=0 (VF=0) SHALL be suppressed (Wreg3 held 0); vector writes to index 0 are allowed.
REQ-012 mem_rvalid in IDLE with no load being accepted SHALL be ignored.
REQ-013 The beat counter SHALL be $clog2(BEATS) bits wide and SHALL never wrap past BEATS-1 within one load.
REQ-014 Lanes not yet written in COLLECT SHALL hold 0.
  - The lane buffer clears on every vector-load accept.
REQ-015 ResRV2, VF3 and R_V_dest3 SHALL hold their last value when Wreg3=0.

Reset
REQ-016 While rst=1, independent of clk, the module SHALL:
  - go to IDLE;
  - drive Wreg3=0, VF3=0, R_V_dest3=0, ResRV2=0 and stall=0;
  - clear the beat counter and lane buffer.
REQ-017 Reset during WAIT_S or COLLECT SHALL discard the partial load, and no write SHALL occur after reset release.
REQ-018 In the first edge after rst falls, the module SHALL accept instructions normally.

Verification
REQ-019 Scalar ALU case:
  - Stimulus: valid_m=1, wreg_m=1, rmem_m=0, VF_m=0, dest=5, ALURes_m[31:0]=0x0000_002A.
  - Required response: the next cycle has Wreg3=1, VF3=0, R_V_dest3=5, ResRV2[31:0]=0x2A; the cycle after has Wreg3=0.
REQ-020 Vector load case:
  - Stimulus: vector load to dest 3, then four beats 0x11111111, 0x22222222, 0x33333333, 0x44444444, one per cycle.
  - Required response: stall=1 from the accept cycle through the fourth beat; then a single COMMIT cycle with ResRV2=0x44444444_33333333_22222222_11111111, VF3=1, R_V_dest3=3.
REQ-021 Gapped beats case:
  - Stimulus: a vector load with mem_rvalid idle for 2 cycles between beats 1 and 2.
  - Required response: stall stays 1 through the gap, and the result is the same as REQ-020.
REQ-022 Scalar write to R0 case:
  - Stimulus: scalar write with dest=0.
  - Required response: Wreg3 stays 0.
REQ-023 Reset mid-load case:
  - Stimulus: assert rst after the 2nd beat of a vector load, then release.
  - Required response: stall=0 and Wreg3=0 immediately; no COMMIT pulse ever occurs for that load.
REQ-024 Back-to-back case:
  - Stimulus: a new scalar ALU instruction presented in the COMMIT cycle.
  - Required response: it is accepted, and its Wreg3 pulse immediately follows the vector-load pulse.

Source files
------------

// File: rtl/writeback_module.sv
// Writeback stage: registers ALU/scalar-load results and assembles multi-beat
// vector loads into a 128-bit lane buffer before a single register-file write.
module writeback_module #(
    parameter int BEATS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_m,
    input  logic         wreg_m,
    input  logic         rmem_m,
    input  logic         VF_m,
    input  logic [3:0]   R_V_dest_m,
    input  logic [127:0] ALURes_m,
    input  logic [31:0]  MemData,
    input  logic         mem_rvalid,
    output logic         Wreg3,
    output logic         VF3,
    output logic [3:0]   R_V_dest3,
    output logic [127:0] ResRV2,
    output logic         stall
);
    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, WAIT_S, COLLECT, COMMIT} state_t;

    state_t         state_reg, state_next;
    logic [CW-1:0]  beat_reg, beat_next;
    logic [127:0]   lanes_reg, lanes_next;
    logic [3:0]     dest_reg, dest_next;
    logic           wreg_l_reg, wreg_l_next;

    logic           wreg3_reg, wreg3_next;
    logic           vf3_reg, vf3_next;
    logic [3:0]     dest3_reg, dest3_next;
    logic [127:0]   res_reg, res_next;

    logic           ready;
    logic           accept;
    logic           wr_en;
    logic           wr_vf;
    logic [3:0]     wr_dest;
    logic [127:0]   wr_data;

    // A new instruction can only enter while nothing is pending (IDLE or the
    // commit cycle of a vector load).
    assign ready  = (state_reg == IDLE) || (state_reg == COMMIT);
    assign accept = valid_m && ready;
    assign stall  = !rst && (!ready || (accept && rmem_m && VF_m));

    assign Wreg3     = wreg3_reg;
    assign VF3       = vf3_reg;
    assign R_V_dest3 = dest3_reg;
    assign ResRV2    = res_reg;

    always_comb begin
        state_next  = state_reg;
        beat_next   = beat_reg;
        lanes_next  = lanes_reg;
        dest_next   = dest_reg;
        wreg_l_next = wreg_l_reg;
        wr_en       = 1'b0;
        wr_vf       = 1'b0;
        wr_dest     = 4'd0;
        wr_data     = '0;

        case (state_reg)
            IDLE, COMMIT: begin
                state_next = IDLE;
                if (accept) begin
                    if (!rmem_m) begin
                        wr_en   = wreg_m && !(!VF_m && R_V_dest_m == 4'd0);
                        wr_vf   = VF_m;
                        wr_dest = R_V_dest_m;
                        wr_data = ALURes_m;
                    end else if (VF_m) begin
                        // Beats presented alongside the accept are not captured.
                        state_next = COLLECT;
                        beat_next  = '0;
                        lanes_next = '0;
                        dest_next  = R_V_dest_m;
                    end else if (mem_rvalid) begin
                        wr_en   = wreg_m && (R_V_dest_m != 4'd0);
                        wr_dest = R_V_dest_m;
                        wr_data = {96'h0, MemData};
                    end else begin
                        state_next  = WAIT_S;
                        dest_next   = R_V_dest_m;
                        wreg_l_next = wreg_m;
                    end
                end
            end
            WAIT_S: begin
                if (mem_rvalid) begin
                    state_next = IDLE;
                    wr_en      = wreg_l_reg && (dest_reg != 4'd0);
                    wr_dest    = dest_reg;
                    wr_data    = {96'h0, MemData};
                end
            end
            COLLECT: begin
                if (mem_rvalid) begin
                    lanes_next[{beat_reg, 5'b0} +: 32] = MemData;
                    if (beat_reg == LAST_BEAT) begin
                        state_next = COMMIT;
                        wr_en      = 1'b1;
                        wr_vf      = 1'b1;
                        wr_dest    = dest_reg;
                        wr_data    = lanes_next;
                    end else begin
                        beat_next = beat_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase

        // Write-port fields only move on an actual write so they hold otherwise.
        wreg3_next = wr_en;
        vf3_next   = wr_en ? wr_vf   : vf3_reg;
        dest3_next = wr_en ? wr_dest : dest3_reg;
        res_next   = wr_en ? wr_data : res_reg;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            beat_reg   <= '0;
            lanes_reg  <= '0;
            dest_reg   <= '0;
            wreg_l_reg <= 1'b0;
            wreg3_reg  <= 1'b0;
            vf3_reg    <= 1'b0;
            dest3_reg  <= '0;
            res_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            beat_reg   <= beat_next;
            lanes_reg  <= lanes_next;
            dest_reg   <= dest_next;
            wreg_l_reg <= wreg_l_next;
            wreg3_reg  <= wreg3_next;
            vf3_reg    <= vf3_next;
            dest3_reg  <= dest3_next;
            res_reg    <= res_next;
        end
    end
endmodule

// File: tb/tb_writeback_module.sv
// Directed bench for writeback_module: a transaction-level model checked every
// cycle on the falling edge, plus literal expectations at key points.
module tb_writeback_module;
    localparam int BEATS = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         valid_m = 1'b0, wreg_m = 1'b0, rmem_m = 1'b0, VF_m = 1'b0;
    logic [3:0]   R_V_dest_m = 4'd0;
    logic [127:0] ALURes_m = '0;
    logic [31:0]  MemData = '0;
    logic         mem_rvalid = 1'b0;
    logic         Wreg3, VF3, stall;
    logic [3:0]   R_V_dest3;
    logic [127:0] ResRV2;

    int total = 0;
    int bad = 0;

    writeback_module #(.BEATS(BEATS)) dut (
        .clk(clk), .rst(rst), .valid_m(valid_m), .wreg_m(wreg_m), .rmem_m(rmem_m),
        .VF_m(VF_m), .R_V_dest_m(R_V_dest_m), .ALURes_m(ALURes_m), .MemData(MemData),
        .mem_rvalid(mem_rvalid), .Wreg3(Wreg3), .VF3(VF3), .R_V_dest3(R_V_dest3),
        .ResRV2(ResRV2), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Model: pending kind 0=none, 1=scalar load awaiting data, 2=vector load.
    int           kind = 0;
    logic [3:0]   pdest = 4'd0;
    logic         pwreg = 1'b0;
    logic [31:0]  beats[$];
    logic         exp_w = 1'b0, exp_vf = 1'b0;
    logic [3:0]   exp_dest = 4'd0;
    logic [127:0] exp_res = '0;

    task automatic model_write(input logic en, input logic vf, input logic [3:0] d, input logic [127:0] data);
        exp_w = en;
        if (en) begin
            exp_vf   = vf;
            exp_dest = d;
            exp_res  = data;
            $display("txn write vf=%0b dest=%0d data=%h", vf, d, data);
        end
    endtask

    always @(negedge clk) begin
        logic         exp_stall;
        logic [127:0] vec;
        if (rst) begin
            kind = 0;
            beats.delete();
            exp_w = 1'b0; exp_vf = 1'b0; exp_dest = 4'd0; exp_res = '0;
        end
        chk("m_wreg3", 128'(Wreg3), 128'(exp_w));
        chk("m_vf3", 128'(VF3), 128'(exp_vf));
        chk("m_dest3", 128'(R_V_dest3), 128'(exp_dest));
        chk("m_res", ResRV2, exp_res);
        exp_stall = !rst && (kind != 0 || (valid_m && rmem_m && VF_m));
        chk("m_stall", 128'(stall), 128'(exp_stall));
        if (!rst) begin
            exp_w = 1'b0;
            if (kind == 0 && valid_m) begin
                if (!rmem_m)
                    model_write(wreg_m && !(!VF_m && R_V_dest_m == 0), VF_m, R_V_dest_m, ALURes_m);
                else if (VF_m) begin
                    kind = 2; pdest = R_V_dest_m; beats.delete();
                end else if (mem_rvalid)
                    model_write(wreg_m && R_V_dest_m != 0, 1'b0, R_V_dest_m, {96'h0, MemData});
                else begin
                    kind = 1; pdest = R_V_dest_m; pwreg = wreg_m;
                end
            end else if (kind == 1 && mem_rvalid) begin
                model_write(pwreg && pdest != 0, 1'b0, pdest, {96'h0, MemData});
                kind = 0;
            end else if (kind == 2 && mem_rvalid) begin
                beats.push_back(MemData);
                if (beats.size() == BEATS) begin
                    vec = '0;
                    foreach (beats[i]) vec[32*i +: 32] = beats[i];
                    model_write(1'b1, 1'b1, pdest, vec);
                    kind = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic rm, input logic vf,
                         input logic [3:0] d, input logic [127:0] alu,
                         input logic [31:0] md, input logic rv);
        valid_m = v; wreg_m = w; rmem_m = rm; VF_m = vf; R_V_dest_m = d;
        ALURes_m = alu; MemData = md; mem_rvalid = rv;
    endtask

    task automatic idle_in(input logic [31:0] md, input logic rv);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 128'h0, md, rv);
    endtask

    task automatic vec_beats(input logic [3:0] d, input int gap);
        drive(1'b1, 1'b1, 1'b1, 1'b1, d, 128'h0, 32'hBADBAD00, 1'b1);
        tick();
        chk("vacc_stall", 128'(stall), 128'(1));
        idle_in(32'h11111111, 1'b1); tick();
        for (int i = 0; i < gap; i++) begin
            // Instructions presented while stalled must be ignored.
            drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd6, 128'hEE, 32'h0, 1'b0);
            tick();
            chk("gap_stall", 128'(stall), 128'(1));
        end
        idle_in(32'h22222222, 1'b1); tick();
        chk("mid_stall", 128'(stall), 128'(1));
        idle_in(32'h33333333, 1'b1); tick();
        idle_in(32'h44444444, 1'b1); tick();
        chk("v_wreg3", 128'(Wreg3), 128'(1));
        chk("v_vf3", 128'(VF3), 128'(1));
        chk("v_dest3", 128'(R_V_dest3), 128'(d));
        chk("v_res", ResRV2, 128'h44444444_33333333_22222222_11111111);
    endtask

    initial begin
        idle_in(32'h0, 1'b0);
        tick(); tick();
        chk("rst_wreg3", 128'(Wreg3), 128'(0));
        chk("rst_res", ResRV2, 128'h0);
        chk("rst_stall", 128'(stall), 128'(0));
        rst = 1'b0;
        idle_in(32'h0, 1'b0); tick();

        // Scalar ALU write, dest 5.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 128'hFFFF0000_0000002A, 32'h0, 1'b0);
        tick();
        chk("alu_wreg3", 128'(Wreg3), 128'(1));
        chk("alu_dest3", 128'(R_V_dest3), 128'(5));
        chk("alu_res", 128'(ResRV2[31:0]), 128'h2A);
        idle_in(32'h0, 1'b0); tick();
        chk("alu_pulse", 128'(Wreg3), 128'(0));

        // Vector load, then back-to-back ALU op in the commit cycle.
        vec_beats(4'd3, 0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 128'h55, 32'h0, 1'b0);
        tick();
        chk("b2b_wreg3", 128'(Wreg3), 128'(1));
        chk("b2b_dest3", 128'(R_V_dest3), 128'(7));
        idle_in(32'h0, 1'b0); tick();

        // Gapped vector load.
        vec_beats(4'd3, 2);
        idle_in(32'h0, 1'b0); tick();

        // Scalar write to R0 is suppressed.
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 128'h77, 32'h0, 1'b0);
        tick();
        chk("r0_wreg3", 128'(Wreg3), 128'(0));
        idle_in(32'h0, 1'b0); tick();

        // Scalar load with data in the accept cycle.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd9, 128'hABCD, 32'hDEADBEEF, 1'b1);
        tick();
        chk("sld_res", ResRV2, {96'h0, 32'hDEADBEEF});
        // Scalar load waiting for data.
        drive(1'b1, 1'b1, 1'b1, 1'b0, 4'd10, 128'h0, 32'h0, 1'b0);
        tick();
        idle_in(32'h0, 1'b0); tick();
        chk("wait_stall", 128'(stall), 128'(1));
        idle_in(32'h12345678, 1'b1); tick();
        chk("wld_dest3", 128'(R_V_dest3), 128'(10));
        chk("wld_res", ResRV2, {96'h0, 32'h12345678});
        idle_in(32'h0, 1'b0); tick();

        // Reset after the second beat of a vector load.
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 128'h0, 32'h0, 1'b0);
        tick();
        idle_in(32'hA, 1'b1); tick();
        idle_in(32'hB, 1'b1); tick();
        rst = 1'b1;
        idle_in(32'hC, 1'b1);
        #1;
        chk("mrst_stall", 128'(stall), 128'(0));
        chk("mrst_wreg3", 128'(Wreg3), 128'(0));
        tick(); tick();
        rst = 1'b0;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd4, 128'h99, 32'hD, 1'b1);
        tick();
        chk("post_rst_acc", 128'(Wreg3), 128'(1));
        for (int i = 0; i < 6; i++) begin
            idle_in(32'hE0 + i, 1'b1);
            tick();
        end
        idle_in(32'h0, 1'b0);
        tick(); tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
